// File: rtl/gba_video_pkg.sv
// Shared GBA video constants and types for the frame double-buffer.
package gba_video_pkg;

  localparam int GBA_COLS   = 240;
  localparam int GBA_ROWS   = 160;
  localparam int GBA_PIXELS = GBA_COLS * GBA_ROWS;

  // {R[14:10], G[9:5], B[4:0]}
  typedef logic [14:0] pixel_t;

  // FILL: back buffer is being written; HOLD: back buffer complete, awaiting swap
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } dbuf_state_t;

endpackage

// File: rtl/frame_dbuf_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// Contents are not reset so the array maps onto block RAM.
module frame_dbuf_ram
  import gba_video_pkg::*;
#(
  parameter int DEPTH = GBA_PIXELS,
  parameter int IDX_W = 16
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [14:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [14:0]      rdata
);

  pixel_t mem [DEPTH];
  pixel_t rdata_reg;

  // Write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its last value when not enabled
  always_ff @(posedge clock) begin
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/frame_dbuf.sv
// Double-buffered frame store between the GBA pixel pipeline and VGA scan-out.
// The producer fills the back buffer; buffers swap only on a VGA frame_sync
// once a full frame is held, so the displayed frame never tears.
// Optional build macro FRAME_DBUF_STATS_EN adds repeat_cnt / swap_cnt outputs.
module frame_dbuf #(
  parameter int GBA_COLS = 240,
  parameter int GBA_ROWS = 160,
  parameter int ADDR_W   = 17
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [14:0]       pix_data,
  input  logic              pix_sof,
  input  logic              frame_sync,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [14:0]       rd_data,
  output logic              front_sel,
`ifdef FRAME_DBUF_STATS_EN
  output logic [15:0]       repeat_cnt,
  output logic [15:0]       swap_cnt,
`endif
  output logic              sync_err
);

  import gba_video_pkg::*;

  localparam int GBA_PIXELS = GBA_COLS * GBA_ROWS;
  localparam int IDX_W      = $clog2(GBA_PIXELS);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(GBA_PIXELS - 1);

  dbuf_state_t       state_reg;
  logic [ADDR_W-1:0] wr_idx_reg;
  logic              front_sel_reg;
  logic              pix_ready_reg;
  logic              sync_err_reg;
  logic              rd_hit_reg;
  logic              rd_sel_reg;
`ifdef FRAME_DBUF_STATS_EN
  logic [15:0]       repeat_cnt_reg;
  logic [15:0]       swap_cnt_reg;
`endif

  logic              accept;
  logic              resync;
  logic              rd_hit;
  logic [IDX_W-1:0]  wr_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic              buf_we [2];
  logic              buf_re [2];
  pixel_t            buf_q  [2];

  // pix_ready is only high in FILL, so an accept never happens in HOLD
  assign accept  = pix_valid && pix_ready_reg;
  // Start-of-frame marker arriving mid-frame restarts the frame at address 0
  assign resync  = pix_sof && (wr_idx_reg != '0);
  assign wr_addr = resync ? '0 : wr_idx_reg[IDX_W-1:0];
  assign rd_hit  = (rd_addr <= PIX_LAST);
  assign rd_idx  = rd_addr[IDX_W-1:0];

  // Writes go to the back buffer, reads to the front buffer; out-of-range reads touch neither
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      localparam logic BUF_ID = 1'(gi);

      assign buf_we[gi] = accept && (front_sel_reg != BUF_ID);
      assign buf_re[gi] = rd_hit && (front_sel_reg == BUF_ID);

      frame_dbuf_ram #(
        .DEPTH (GBA_PIXELS),
        .IDX_W (IDX_W)
      ) u_ram (
        .clock (clock),
        .we    (buf_we[gi]),
        .waddr (wr_addr),
        .wdata (pix_data),
        .re    (buf_re[gi]),
        .raddr (rd_idx),
        .rdata (buf_q[gi])
      );
    end
  endgenerate

  // Fill/hold controller: write index, swap decision, status flags
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_reg      <= FILL;
      wr_idx_reg     <= '0;
      front_sel_reg  <= 1'b0;
      pix_ready_reg  <= 1'b1;
      sync_err_reg   <= 1'b0;
`ifdef FRAME_DBUF_STATS_EN
      repeat_cnt_reg <= '0;
      swap_cnt_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            if (resync) begin
              wr_idx_reg   <= ADDR_W'(1);
              sync_err_reg <= 1'b1;
            end else if (wr_idx_reg == PIX_LAST) begin
              wr_idx_reg    <= '0;
              state_reg     <= HOLD;
              pix_ready_reg <= 1'b0;
            end else begin
              wr_idx_reg <= wr_idx_reg + ADDR_W'(1);
            end
          end
`ifdef FRAME_DBUF_STATS_EN
          // VGA repeats the old frame; count it, saturating
          if (frame_sync && (repeat_cnt_reg != 16'hFFFF)) begin
            repeat_cnt_reg <= repeat_cnt_reg + 16'd1;
          end
`endif
        end
        HOLD: begin
          if (frame_sync) begin
            front_sel_reg <= ~front_sel_reg;
            state_reg     <= FILL;
            pix_ready_reg <= 1'b1;
`ifdef FRAME_DBUF_STATS_EN
            swap_cnt_reg  <= swap_cnt_reg + 16'd1;
`endif
          end
        end
        default: begin
          state_reg     <= FILL;
          pix_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Capture read qualifiers alongside the address so a same-edge swap cannot affect this read
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      rd_hit_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      rd_hit_reg <= rd_hit;
      rd_sel_reg <= front_sel_reg;
    end
  end

  assign rd_data    = rd_hit_reg ? buf_q[rd_sel_reg] : 15'd0;
  assign pix_ready  = pix_ready_reg;
  assign front_sel  = front_sel_reg;
  assign sync_err   = sync_err_reg;
`ifdef FRAME_DBUF_STATS_EN
  assign repeat_cnt = repeat_cnt_reg;
  assign swap_cnt   = swap_cnt_reg;
`endif

endmodule
